cdb_arbiter: RTL and testbench

- Multi-channel common data bus (CDB) that arbitrates completed results from NUM_CH functional units (e.g. ALU, MUL/DIV, LSU, branch) onto a single registered broadcast bus.
- One winner per cycle; the broadcast is read by the ROB and all reservation stations.
- Successor to the single-channel ALU pass-through CDB. Adds:
  - round-robin arbitration;
  - a valid/ready handshake per channel;
  - a registered output stage;
  - source-channel tagging;
  - pipeline flush.

---
 rtl/cdb_arbiter.sv | 80 ++++++++
 tb/tb_cdb_arbiter.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// Common data bus: round-robin arbitration of NUM_CH producer channels onto one
// registered broadcast beat per cycle, with source tagging and pipeline flush.
module cdb_arbiter #(
  parameter int NUM_CH          = 4,
  parameter int DATA_WIDTH      = 32,
  parameter int ROB_ENTRY_WIDTH = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              flush,
  input  logic [NUM_CH-1:0]                 req_valid,
  input  logic [NUM_CH*DATA_WIDTH-1:0]      req_data,
  input  logic [NUM_CH*ROB_ENTRY_WIDTH-1:0] req_dest,
  output logic [NUM_CH-1:0]                 req_ready,
  output logic                              cdb_valid,
  output logic [DATA_WIDTH-1:0]             cdb_data,
  output logic [ROB_ENTRY_WIDTH-1:0]        cdb_dest,
  output logic [$clog2(NUM_CH)-1:0]         cdb_src
);

  localparam int CH_W = $clog2(NUM_CH);

  logic [CH_W-1:0]            rr_ptr;
  logic [CH_W-1:0]            win_idx;
  logic [CH_W-1:0]            next_ptr;
  logic                       win_found;
  logic [NUM_CH-1:0]          grant;
  logic [DATA_WIDTH-1:0]      win_data;
  logic [ROB_ENTRY_WIDTH-1:0] win_dest;
  logic                       take;

  // Priority search starting at rr_ptr, wrapping modulo NUM_CH.
  always_comb begin
    grant     = '0;
    win_idx   = '0;
    win_found = 1'b0;
    win_data  = '0;
    win_dest  = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      int unsigned idx;
      idx = (32'(rr_ptr) + k) % NUM_CH;
      if (!win_found && req_valid[idx]) begin
        win_found  = 1'b1;
        win_idx    = CH_W'(idx);
        grant[idx] = 1'b1;
        win_data   = req_data[idx*DATA_WIDTH +: DATA_WIDTH];
        win_dest   = req_dest[idx*ROB_ENTRY_WIDTH +: ROB_ENTRY_WIDTH];
      end
    end
  end

  always_comb begin
    take      = win_found && !rst && !flush;
    req_ready = take ? grant : '0;
    next_ptr  = (win_idx == CH_W'(NUM_CH - 1)) ? '0 : win_idx + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cdb_valid <= 1'b0;
      cdb_data  <= '0;
      cdb_dest  <= '0;
      cdb_src   <= '0;
      rr_ptr    <= '0;
    end else if (take) begin
      cdb_valid <= 1'b1;
      cdb_data  <= win_data;
      cdb_dest  <= win_dest;
      cdb_src   <= win_idx;
      rr_ptr    <= next_ptr;
    end else begin
      // Flush and idle edges both emit a zero-payload invalid beat; rr_ptr holds.
      cdb_valid <= 1'b0;
      cdb_data  <= '0;
      cdb_dest  <= '0;
      cdb_src   <= '0;
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: reference model predicts grants and
// queues the expected broadcast beat, which is compared one cycle later.
module tb_cdb_arbiter;

  localparam int NCH = 4;

  typedef struct packed {
    logic        v;
    logic [31:0] d;
    logic [7:0]  t;
    logic [1:0]  s;
  } beat_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic [3:0]   vld;
  logic [31:0]  dat [NCH];
  logic [7:0]   dst [NCH];
  logic [127:0] req_data;
  logic [31:0]  req_dest;
  logic [3:0]   req_ready;
  logic         cdb_valid;
  logic [31:0]  cdb_data;
  logic [7:0]   cdb_dest;
  logic [1:0]   cdb_src;

  int    n_tests = 0;
  int    n_fail  = 0;
  int    m_ptr   = 0;
  int    last_w;
  beat_t exp_q[$];

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      req_data[i*32 +: 32] = dat[i];
      req_dest[i*8 +: 8]   = dst[i];
    end
  end

  cdb_arbiter #(.NUM_CH(4), .DATA_WIDTH(32), .ROB_ENTRY_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(vld), .req_data(req_data), .req_dest(req_dest),
    .req_ready(req_ready),
    .cdb_valid(cdb_valid), .cdb_data(cdb_data), .cdb_dest(cdb_dest), .cdb_src(cdb_src)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: predict and check the grant, queue the beat, then check the CDB.
  task automatic cycle();
    beat_t      e;
    logic [3:0] er;
    int         w;
    #1;
    er = '0;
    e  = '0;
    w  = -1;
    if (!rst && !flush)
      for (int k = 0; k < NCH; k++) begin
        int idx;
        idx = (m_ptr + k) % NCH;
        if (w < 0 && vld[idx]) w = idx;
      end
    if (w >= 0) begin
      er[w] = 1'b1;
      e     = '{v: 1'b1, d: dat[w], t: dst[w], s: 2'(w)};
      m_ptr = (w + 1) % NCH;
    end
    if (rst) m_ptr = 0;
    chk("req_ready", 64'(req_ready), 64'(er));
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    e = exp_q.pop_front();
    chk("cdb_valid", 64'(cdb_valid), 64'(e.v));
    chk("cdb_data",  64'(cdb_data),  64'(e.d));
    chk("cdb_dest",  64'(cdb_dest),  64'(e.t));
    chk("cdb_src",   64'(cdb_src),   64'(e.s));
    last_w = w;
    if (w >= 0) begin
      dat[w] = $urandom;
      dst[w] = 8'($urandom);
    end
  endtask

  initial begin
    int order [6];
    rst   = 1'b1;
    flush = 1'b0;
    vld   = '0;
    for (int i = 0; i < NCH; i++) begin
      dat[i] = $urandom;
      dst[i] = 8'($urandom);
    end

    // Reset then idle
    repeat (2) cycle();
    rst = 1'b0;
    cycle();

    // Single channel: ch2
    vld = 4'b0100; dat[2] = 32'hDEADBEEF; dst[2] = 8'h15;
    #1 chk("sc_ready", 64'(req_ready), 64'h4);
    cycle();
    vld = '0;
    chk("sc_data", 64'(cdb_data), 64'hDEADBEEF);
    chk("sc_dest", 64'(cdb_dest), 64'h15);
    chk("sc_src",  64'(cdb_src),  64'h2);
    cycle();
    chk("sc_idle", 64'(cdb_valid), 64'h0);

    // Wrap and skip: rr_ptr is 3, ch1 and ch3 held valid
    vld = 4'b1010;
    cycle(); chk("wrap_g0", 64'(last_w), 64'd3);
    cycle(); chk("wrap_g1", 64'(last_w), 64'd1);
    cycle(); chk("wrap_g2", 64'(last_w), 64'd3);

    // Flush: ch0 granted, then flush with ch1 valid, then ch1 granted
    vld = 4'b0001;
    cycle();
    vld = 4'b0010; flush = 1'b1;
    chk("fl_beat_src", 64'(cdb_src), 64'h0);
    cycle();
    flush = 1'b0;
    chk("fl_drop", 64'(cdb_valid), 64'h0);
    cycle(); chk("fl_g_ch1", 64'(last_w), 64'd1);
    vld = '0;
    cycle();

    // Reset, then round-robin under full load
    rst = 1'b1; cycle(); rst = 1'b0;
    vld = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      cycle();
      order[i] = last_w;
    end
    for (int i = 0; i < 6; i++) chk("rr_order", 64'(order[i]), 64'(i % 4));

    // Reset mid-stream: ch0 first afterwards
    rst = 1'b1; cycle(); rst = 1'b0;
    cycle(); chk("rst_ch0", 64'(last_w), 64'd0);

    // Random traffic; ungranted channels hold their request
    for (int n = 0; n < 300; n++) begin
      cycle();
      for (int i = 0; i < NCH; i++)
        if (!vld[i] || i == last_w) vld[i] = 1'($urandom_range(0, 1));
      flush = ($urandom_range(0, 15) == 0);
      rst   = ($urandom_range(0, 31) == 0);
    end
    rst = 1'b0; flush = 1'b0; vld = '0;
    cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
